// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage pipelined execute-stage shift unit with valid/ready flow control.
// Optional feature: define SHIFT_ROTATE_EN to give op 2'b10 the ROR meaning. Without it,
// op 2'b10 returns 0 with out_err set.
// Ports: clk, rst (async, active-high), flush (synchronous kill of in-flight ops);
//   in_valid/in_ready/in_op/in_data/in_shamt/in_tag carry the upstream micro-op;
//   out_valid/out_ready/out_data/out_tag/out_err carry the tagged result;
//   busy is high while either stage holds an op.
module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic                    s1_valid_q, s1_valid_d;
    logic [1:0]              s1_op_q, s1_op_d;
    logic [31:0]             s1_data_q, s1_data_d;
    logic [4:0]              s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [31:0]             s2_data_q, s2_data_d;
    logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;
    logic                    s2_err_q, s2_err_d;
    logic                    s2_adv, s1_adv, in_fire;
    logic [31:0]             rev_in, sh_in, srl_out, sh_out, rev_out, res;
    logic signed [31:0]      sra_out;
    logic                    err;

    assign s2_adv   = !s2_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = !rst & !flush & (!s1_valid_q | s2_adv);
    assign in_fire  = in_valid & in_ready;

    // Left shifts reuse the right shifter by mirroring the operand and the result.
    always_comb begin
        for (int i = 0; i < 32; i++) rev_in[i] = s1_data_q[31-i];
    end

    assign sh_in   = (s1_op_q == OP_SLL) ? rev_in : s1_data_q;
    assign srl_out = sh_in >> s1_shamt_q;
    // Kept as its own signed net so the mixed-sign ternary below cannot turn it logical.
    assign sra_out = $signed(sh_in) >>> s1_shamt_q;
    assign sh_out  = (s1_op_q == OP_SRA) ? sra_out : srl_out;

    always_comb begin
        for (int i = 0; i < 32; i++) rev_out[i] = sh_out[31-i];
    end

    always_comb begin
        res = (s1_op_q == OP_SLL) ? rev_out : sh_out;
        err = 1'b0;
        if (s1_op_q == OP_ROR) begin
`ifdef SHIFT_ROTATE_EN
            // A shift by 32 yields 0 here, so shamt 0 returns data unchanged.
            res = (s1_data_q >> s1_shamt_q) | (s1_data_q << (6'd32 - {1'b0, s1_shamt_q}));
`else
            res = 32'h0;
            err = 1'b1;
`endif
        end
    end

    always_comb begin
        s1_valid_d = flush ? 1'b0 : in_fire ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
        s1_op_d    = in_fire ? in_op : s1_op_q;
        s1_data_d  = in_fire ? in_data : s1_data_q;
        s1_shamt_d = in_fire ? in_shamt : s1_shamt_q;
        s1_tag_d   = in_fire ? in_tag : s1_tag_q;
        s2_valid_d = flush ? 1'b0 : s2_adv ? s1_valid_q : s2_valid_q;
        s2_data_d  = s1_adv ? res : s2_data_q;
        s2_tag_d   = s1_adv ? s1_tag_q : s2_tag_q;
        s2_err_d   = s1_adv ? err : s2_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 2'b00;
            s1_data_q  <= 32'h0;
            s1_shamt_q <= 5'd0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'h0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_shamt_q <= s1_shamt_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;
    assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined execute-stage shift unit of the CPU datapath.
- Accepts decoded shift micro-ops (operand, shift amount, op code, destination tag) over a valid/ready handshake.
- Computes the result through the team's 32-bit right barrel shifter (logical/arithmetic). Left shifts use bit-reversal around that shifter.
- Delivers the tagged result downstream to writeback/forwarding with full backpressure and pipeline flush support.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept an operation this cycle.
- in_op  input  2  2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 ROR (feature-dependent).
- in_data  input  32  operand to shift.
- in_shamt  input  5  shift amount 0..31.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  shift result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  result came from an unsupported op.
- busy  output  1  s1_valid | s2_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Two register stages:
  - S1 captures op, data, shamt and tag.
  - S2 holds the computed result, tag and err.
  - Each stage has its own valid bit.
- Handshakes:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
- Latency and throughput: 2 cycles from accepting edge to out_valid. Throughput 1 op/cycle with out_ready held high.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !rst & !flush & (!s1_valid | s2_adv).
  - in_ready is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- Stall: while out_valid & !out_ready, out_data, out_tag and out_err stay stable. S1 holds its contents. No operation is dropped or duplicated.
- S2 computation (combinational between S1 and S2):
  - SRL: right shifter, logical mode.
  - SRA: right shifter, arithmetic mode (sign fill).
  - SLL: reverse(data) -> logical right shift by shamt -> reverse.
  - Amounts use only 5 bits. shamt 0 returns data unchanged for every op.
- Reset (async):
  - s1_valid, s2_valid, out_valid, out_err cleared to 0.
  - out_data cleared to 32'h0, out_tag to 0.
  - While rst is high, in_ready = 0 and busy = 0.
  - Reset mid-operation discards all in-flight work. No result emerges after deassertion.
- Flush:
  - Next edge clears s1_valid and s2_valid, even if out_ready is high that cycle.
  - in_ready = 0 during the flush cycle, so no input is captured.
  - out_data and out_tag need not be cleared.
- Simultaneous S1->S2 advance, new input capture and output transfer in one cycle is legal and required (full pipeline flow).

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: op 2'b10 = ROR, result = (data >> shamt) | (data << (32 - shamt)); shamt 0 returns data. out_err is always 0.
- Undefined: op 2'b10 is unsupported; result out_data = 32'h0 with out_err = 1, still tagged and handshaken normally. No rotate logic is synthesised.

Test Plan:
- Basic ops, out_ready = 1, back-to-back:
  - SLL 32'h0000_0001 by 31 -> 32'h8000_0000.
  - SRL 32'h8000_0000 by 31 -> 32'h0000_0001.
  - SRA 32'h8000_0000 by 4 -> 32'hF800_0000.
  - Each result arrives exactly 2 cycles after acceptance, one per cycle, tags preserved in order.
- Zero shift: SRA 32'hDEAD_BEEF by 0 -> 32'hDEAD_BEEF. SLL by 0 -> 32'hDEAD_BEEF.
- Backpressure:
  - Issue 3 ops, hold out_ready = 0 for 5 cycles.
  - in_ready drops once S1 and S2 are both full.
  - Outputs hold stable; on release, all 3 results emerge in order with no loss or duplication.
- Flush: flush high with 2 ops in flight and in_valid high -> next cycle out_valid = 0, busy = 0; the flushed-cycle input is never produced.
- Async reset mid-stream: assert rst between clock edges with ops in flight -> out_valid = 0, out_data = 0 immediately. No stale results after release.
- Op 2'b10 on 32'h0000_00F1 by 4:
  - With SHIFT_ROTATE_EN: 32'h1000_000F, out_err = 0.
  - Without: 32'h0, out_err = 1.
